data_mem_wbuf: RTL

DATA_MEM_WBUF -- requirements
Module: data_mem_wbuf

---
 rtl/data_mem_wbuf_pkg.sv | 28 ++
 rtl/data_mem_wbuf_fifo.sv | 88 ++++++++
 rtl/data_mem_wbuf.sv | 86 ++++++++
 3 files changed

// File: rtl/data_mem_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_wbuf_pkg
// Brief    : Shared types and helpers for the data-memory write buffer.
// Revision : 1.0
// ============================================================================
package data_mem_wbuf_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  // Entries carry the widest supported address; unused upper bits stay zero.
  localparam int unsigned AW_MAX = 64;

  typedef struct packed {
    logic [AW_MAX-1:0] addr;
    logic [31:0]       data;
  } entry_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_wbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wbuf_fifo
// Brief    : In-order store FIFO exposing every entry and its valid bit.
// Revision : 1.0
// ============================================================================
module wbuf_fifo
  import data_mem_wbuf_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PW    = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  entry_t                 i_push_entry,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [PW-1:0]          o_head_ptr,
  output entry_t [DEPTH-1:0]     o_entries,
  output logic [DEPTH-1:0]       o_valid
);

  localparam int unsigned        CW           = PW + 1;
  localparam logic [CW-1:0]      c_full_count = CW'(DEPTH);

  logic [PW-1:0]      head_ptr_q, head_ptr_d;
  logic [PW-1:0]      tail_ptr_q, tail_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  entry_t [DEPTH-1:0] entries_q, entries_d;

  logic w_full, w_empty, w_do_push, w_do_pop;

  assign w_full  = (count_q == c_full_count);
  assign w_empty = (count_q == '0);
  // A full buffer refuses the store even if the head drains this cycle.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_comb begin
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    entries_d  = entries_q;

    if (w_do_pop) begin
      valid_d[head_ptr_q] = 1'b0;
      head_ptr_d          = head_ptr_q + PW'(1);
    end
    if (w_do_push) begin
      entries_d[tail_ptr_q] = i_push_entry;
      valid_d[tail_ptr_q]   = 1'b1;
      tail_ptr_d            = tail_ptr_q + PW'(1);
    end

    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
      valid_q    <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      entries_q  <= entries_d;
    end
  end

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_head_ptr = head_ptr_q;
  assign o_entries  = entries_q;
  assign o_valid    = valid_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_wbuf
// Brief    : Posted-store write buffer with youngest-match load forwarding.
// Revision : 1.0
// ============================================================================
module data_mem_wbuf
  import data_mem_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ALUOut,
  input  logic [31:0]   WriteData,
  input  logic          MemWrite,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_wreq,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_wack
);

  localparam int unsigned PW = clog2(DEPTH);

  logic                 w_full, w_empty, w_push;
  logic [PW-1:0]        w_head_ptr;
  entry_t [DEPTH-1:0]   w_entries;
  logic [DEPTH-1:0]     w_valid;
  entry_t               w_push_entry;
  entry_t               w_head;
  logic [AW_MAX-1:0]    w_alu_ext;
  logic [PW-1:0]        w_idx;
  logic                 w_fwd_hit;
  logic [31:0]          w_fwd_data;

  assign w_alu_ext         = AW_MAX'(ALUOut);
  assign w_push            = MemWrite && !reset;
  assign w_push_entry.addr = w_alu_ext;
  assign w_push_entry.data = WriteData;

  wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (mem_wack),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_ptr   (w_head_ptr),
    .o_entries    (w_entries),
    .o_valid      (w_valid)
  );

  // Walk oldest to youngest so the last word-address match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_idx = w_head_ptr + PW'(k);
      if (w_valid[w_idx] &&
          (w_entries[w_idx].addr[AW_MAX-1:2] == w_alu_ext[AW_MAX-1:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_entries[w_idx].data;
      end
    end
  end

  assign w_head    = w_entries[w_head_ptr];
  assign ReadData  = w_fwd_hit ? w_fwd_data : mem_rdata;
  assign Stall     = w_full;
  assign mem_raddr = ALUOut;
  assign mem_wreq  = !w_empty;
  // Head storage is not cleared by reset, so the write bus is gated when idle.
  assign mem_waddr = mem_wreq ? AW'(w_head.addr) : '0;
  assign mem_wdata = mem_wreq ? w_head.data : '0;

endmodule
`default_nettype wire
